// File: rtl/pipe_stage_skid.sv
//------------------------------------------------------------------------------
// Module      : pipe_stage_skid
// Description : Pipeline-boundary register with a 2-entry skid buffer.
//               Moves a control bundle and a data bundle across a stage
//               boundary using a valid/ready handshake. in_ready is a
//               registered function of state only, so there is no
//               combinational path from out_ready back to in_ready.
//               Also provides a synchronous flush, bubble-safe control
//               (out_ctrl is zero whenever out_valid is low) and a
//               saturating back-pressure counter.
// Ports       : clk, rst_b (async, active-low)
//               in_valid / in_ready / in_ctrl / in_data   - upstream side
//               out_valid / out_ready / out_ctrl / out_data - downstream side
//               flush     - squash all held entries
//               stall_cnt - cycles with out_valid=1 and out_ready=0
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_skid #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_stall;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_stall    = r_out_valid & ~out_ready;

  // Main register drives the outputs directly. Its control field is cleared
  // whenever the stage goes empty, so a bubble never carries stale enables.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
      r_stall_cnt <= '0;
    end else begin
      // Back-pressure counter is independent of flush and never wraps.
      if (w_stall && (r_stall_cnt != c_cnt_max)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end

      if (flush) begin
        // Data is deliberately left untouched; only validity and control
        // are squashed. Any same-cycle in_fire payload is dropped.
        r_state     <= ST_EMPTY;
        r_in_ready  <= 1'b1;
        r_out_valid <= 1'b0;
        r_main_ctrl <= '0;
        r_skid_ctrl <= '0;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_in_fire) begin
              r_main_ctrl <= in_ctrl;
              r_main_data <= in_data;
              r_out_valid <= 1'b1;
              r_state     <= ST_ONE;
            end
          end
          ST_ONE: begin
            if (w_in_fire && w_out_fire) begin
              r_main_ctrl <= in_ctrl;
              r_main_data <= in_data;
            end else if (w_out_fire) begin
              r_main_ctrl <= '0;
              r_out_valid <= 1'b0;
              r_state     <= ST_EMPTY;
            end else if (w_in_fire) begin
              // Downstream stalled: park the new payload in the skid slot.
              r_skid_ctrl <= in_ctrl;
              r_skid_data <= in_data;
              r_in_ready  <= 1'b0;
              r_state     <= ST_FULL;
            end
          end
          ST_FULL: begin
            if (w_out_fire) begin
              r_main_ctrl <= r_skid_ctrl;
              r_main_data <= r_skid_data;
              r_in_ready  <= 1'b1;
              r_state     <= ST_ONE;
            end
          end
          default: begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_ctrl <= '0;
          end
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;
  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
//------------------------------------------------------------------------------
// Module      : tb_pipe_stage_skid
// Description : Self-checking bench for pipe_stage_skid. A FIFO-of-two
//               reference model (queue of payloads) predicts every output.
//               Directed scenarios are followed by a randomized run.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_skid;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_b;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_stage_skid #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the stage is a 2-deep FIFO; the head is what is shown.
  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } pl_t;

  pl_t               m_q[$];
  logic [DATA_W-1:0] m_last;
  int                m_cnt;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last = '0;
    m_cnt  = 0;
  endtask

  task automatic check_all(input string tag);
    logic              e_valid;
    logic [CTRL_W-1:0] e_ctrl;
    e_valid = (m_q.size() > 0);
    e_ctrl  = e_valid ? m_q[0].c : '0;
    chk({tag, ".in_ready"},  64'(in_ready),  64'(m_q.size() < 2));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(e_valid));
    chk({tag, ".out_ctrl"},  64'(out_ctrl),  64'(e_ctrl));
    chk({tag, ".out_data"},  64'(out_data),  64'(m_last));
    chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
  endtask

  // Called at a falling edge: drive inputs, advance the model by one clock,
  // then compare all outputs at the next falling edge.
  task automatic step(input logic v, input logic [CTRL_W-1:0] c,
                      input logic [DATA_W-1:0] d, input logic ordy,
                      input logic fl, input string tag);
    logic m_vld, m_rdy, infire, outfire;
    pl_t  p;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    m_vld   = (m_q.size() > 0);
    m_rdy   = (m_q.size() < 2);
    infire  = v && m_rdy;
    outfire = m_vld && ordy;
    if (m_vld && !ordy && m_cnt < CNT_MAX) m_cnt++;
    if (fl) begin
      m_q.delete();
    end else begin
      if (outfire) void'(m_q.pop_front());
      if (infire) begin
        p.c = c;
        p.d = d;
        m_q.push_back(p);
      end
    end
    if (m_q.size() > 0) m_last = m_q[0].d;
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst_b     = 1'b0;
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    rst_b     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_b = 1'b1;

    // Stream: one payload per cycle, no stalls.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(i + 1), 32'(32'h10 + i), 1'b1, 1'b0, "stream");
      chk("stream.data", 64'(out_data), 64'(32'h10 + i));
    end
    step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, "stream_drain");
    chk("stream.stall", 64'(stall_cnt), 64'd0);

    // Backpressure fill and ordered release.
    do_reset();
    step(1'b1, 8'h01, 32'hA0, 1'b0, 1'b0, "bp_a0");
    step(1'b1, 8'h02, 32'hA1, 1'b0, 1'b0, "bp_a1");
    chk("bp.in_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h03, 32'hA2, 1'b0, 1'b0, "bp_hold");
      chk("bp.hold_data", 64'(out_data), 64'hA0);
    end
    chk("bp.stall", 64'(stall_cnt), 64'd4);
    step(1'b1, 8'h03, 32'hA2, 1'b1, 1'b0, "bp_rel1");
    chk("bp.rel1", 64'(out_data), 64'hA1);
    step(1'b1, 8'h03, 32'hA2, 1'b1, 1'b0, "bp_rel2");
    chk("bp.rel2", 64'(out_data), 64'hA2);
    step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, "bp_rel3");

    // Flush while FULL; the flush-cycle payload must vanish.
    step(1'b1, 8'h11, 32'hB0, 1'b0, 1'b0, "fl_b0");
    step(1'b1, 8'h12, 32'hB1, 1'b0, 1'b0, "fl_b1");
    step(1'b1, 8'h13, 32'hBB, 1'b0, 1'b1, "fl_flush");
    chk("flush.valid", 64'(out_valid), 64'd0);
    chk("flush.ctrl", 64'(out_ctrl), 64'd0);
    chk("flush.ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, "fl_after");
      chk("flush.no_bb", 64'(out_data == 32'hBB), 64'd0);
    end

    // Bubbles between payloads carrying all-ones control.
    step(1'b1, 8'hFF, 32'hC0, 1'b1, 1'b0, "bub_c0");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'hFF, 32'hDEAD, 1'b1, 1'b0, "bub_gap");
      chk("bubble.ctrl", 64'(out_ctrl), 64'd0);
      chk("bubble.data", 64'(out_data), 64'hC0);
    end
    step(1'b1, 8'hFF, 32'hC1, 1'b1, 1'b0, "bub_c1");

    // Async reset mid-operation with FULL and stall_cnt=7.
    do_reset();
    step(1'b1, 8'h21, 32'hD0, 1'b0, 1'b0, "ar_d0");
    step(1'b1, 8'h22, 32'hD1, 1'b0, 1'b0, "ar_d1");
    for (int i = 0; i < 6; i++) step(1'b1, 8'h23, 32'hD2, 1'b0, 1'b0, "ar_hold");
    chk("areset.pre_cnt", 64'(stall_cnt), 64'd7);
    #2 rst_b = 1'b0;
    #1;
    chk("areset.valid", 64'(out_valid), 64'd0);
    chk("areset.ready", 64'(in_ready), 64'd1);
    chk("areset.ctrl", 64'(out_ctrl), 64'd0);
    chk("areset.data", 64'(out_data), 64'd0);
    chk("areset.cnt", 64'(stall_cnt), 64'd0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    check_all("areset_release");

    // Saturation of the 4-bit stall counter.
    step(1'b1, 8'h31, 32'hE0, 1'b0, 1'b0, "sat_push");
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, "sat_hold");
    chk("sat.cnt", 64'(stall_cnt), 64'(CNT_MAX));
    step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, "sat_drain");
    chk("sat.kept", 64'(stall_cnt), 64'(CNT_MAX));

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           8'($urandom),
           32'($urandom),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0),
           "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
